// File: rtl/deadlock_persist_detector.sv
// Deadlock persistence detector for the cnn_core kernel monitor.
// Declares a sticky deadlock once every dataflow process has been idle or
// blocked, with at least one process not idle and no AXIS port starved, for
// PERSIST_CYCLES consecutive cycles. Captures the offending vectors at the
// declaring edge for the simulation report.
module deadlock_persist_detector #(
    parameter int N_AXIS         = 2,
    parameter int N_INST         = 8,
    parameter int N_IDLE         = 12,
    parameter int PERSIST_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_IDLE-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic [N_INST-1:0] block_snapshot,
    output logic [N_IDLE-1:0] idle_snapshot,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {RUN, SUSPECT, DEADLOCK} state_t;

    // Count value on the edge that completes persistence, and the saturated
    // value held while deadlocked.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PERSIST_CYCLES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             block_nxt;
    logic             load_snap;

    logic active, stuck, ext, cand;

    // Candidate condition: only the per-instance bits take part; the
    // sub-loop idle flags above N_INST are report-only.
    always_comb begin
        active = ~&inst_idle_sigs[N_INST-1:0];
        stuck  = &(inst_idle_sigs[N_INST-1:0] | inst_block_sigs);
        ext    = |axis_block_sigs;
        cand   = active & stuck & ~ext;
    end

    // Next-state, next-count and declaration logic; clear beats cand.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        block_nxt = block;
        load_snap = 1'b0;
        case (state)
            RUN: begin
                cnt_nxt = '0;
                if (!clear && cand) begin
                    if (PERSIST_CYCLES == 1) begin
                        state_nxt = DEADLOCK;
                        cnt_nxt   = CNT_SAT;
                        block_nxt = 1'b1;
                        load_snap = 1'b1;
                    end else begin
                        state_nxt = SUSPECT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            SUSPECT: begin
                if (clear || !cand) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DEADLOCK;
                    cnt_nxt   = CNT_SAT;
                    block_nxt = 1'b1;
                    load_snap = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DEADLOCK: begin
                if (clear) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    block_nxt = 1'b0;
                end else begin
                    cnt_nxt = CNT_SAT;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
                block_nxt = 1'b0;
            end
        endcase
    end

    // State, count, flag and snapshot registers; reset clears everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= RUN;
            cnt            <= '0;
            block          <= 1'b0;
            block_snapshot <= '0;
            idle_snapshot  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            block <= block_nxt;
            if (load_snap) begin
                block_snapshot <= inst_block_sigs;
                idle_snapshot  <= inst_idle_sigs;
            end
        end
    end

    assign stall_count = cnt;

endmodule

// File: tb/tb_deadlock_persist_detector.sv
// Directed bench for deadlock_persist_detector with default parameters.
module tb_deadlock_persist_detector;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  axis_block_sigs;
    logic [11:0] inst_idle_sigs;
    logic [7:0]  inst_block_sigs;
    logic        clear;
    logic        block;
    logic [7:0]  block_snapshot;
    logic [11:0] idle_snapshot;
    logic [15:0] stall_count;

    int tests  = 0;
    int failed = 0;

    deadlock_persist_detector dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .clear           (clear),
        .block           (block),
        .block_snapshot  (block_snapshot),
        .idle_snapshot   (idle_snapshot),
        .stall_count     (stall_count)
    );

    always #5 clock = ~clock;

    // One rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic b, input logic [7:0] bs,
                             input logic [11:0] is, input logic [15:0] sc);
        check({tag, ".block"}, 32'(block), 32'(b));
        check({tag, ".block_snapshot"}, 32'(block_snapshot), 32'(bs));
        check({tag, ".idle_snapshot"}, 32'(idle_snapshot), 32'(is));
        check({tag, ".stall_count"}, 32'(stall_count), 32'(sc));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0;
        tick(); tick();
        check_all("reset", 1'b0, 8'h00, 12'h000, 16'd0);

        // Declaration after 16 edges of all-blocked.
        reset = 1'b0;
        inst_idle_sigs = 12'h000; inst_block_sigs = 8'hFF;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("persist.block_low", 32'(block), 32'd0);
            check("persist.count", 32'(stall_count), 32'(i));
        end
        tick();
        check_all("declare", 1'b1, 8'hFF, 12'h000, 16'd16);
        // Deadlock holds and the count saturates even if cand drops.
        inst_block_sigs = 8'h00;
        tick(); tick();
        check_all("hold", 1'b1, 8'hFF, 12'h000, 16'd16);

        // Clear releases, keeps snapshots.
        clear = 1'b1;
        tick();
        check_all("clear", 1'b0, 8'hFF, 12'h000, 16'd0);
        clear = 1'b0;

        // One edge short, then a single non-blocked instance.
        inst_block_sigs = 8'hFF;
        repeat (15) tick();
        check("short.count15", 32'(stall_count), 32'd15);
        check("short.block15", 32'(block), 32'd0);
        inst_block_sigs = 8'hF7;
        tick();
        check("short.count0", 32'(stall_count), 32'd0);
        check("short.block0", 32'(block), 32'd0);
        inst_block_sigs = 8'hFF;
        repeat (15) tick();
        check("rerun.block15", 32'(block), 32'd0);
        tick();
        check("rerun.block16", 32'(block), 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;

        // AXIS starvation excludes deadlock.
        axis_block_sigs = 2'b01;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (block !== 1'b0 || stall_count !== 16'd0)
                check("axis.hold", {15'd0, block, stall_count}, 32'd0);
        end
        check("axis.final", {15'd0, block, stall_count}, 32'd0);
        axis_block_sigs = 2'b00;
        repeat (15) tick();
        check("axis.release15", 32'(block), 32'd0);
        tick();
        check("axis.release16", 32'(block), 32'd1);
        check("axis.count", 32'(stall_count), 32'd16);
        clear = 1'b1; tick(); clear = 1'b0;

        // Kernel at rest: all instances idle, none blocked.
        inst_idle_sigs = 12'h0FF; inst_block_sigs = 8'h00;
        repeat (50) tick();
        check("rest.block", 32'(block), 32'd0);
        check("rest.count", 32'(stall_count), 32'd0);

        // Mixed idle and blocked.
        inst_idle_sigs = 12'h00F; inst_block_sigs = 8'hF0;
        repeat (15) tick();
        check("mixed.block15", 32'(block), 32'd0);
        tick();
        check_all("mixed", 1'b1, 8'hF0, 12'h00F, 16'd16);
        clear = 1'b1;
        tick();
        check_all("mixed.clear", 1'b0, 8'hF0, 12'h00F, 16'd0);

        // Clear held with cand true in RUN keeps it in RUN.
        tick(); tick();
        check("clearwins.count", 32'(stall_count), 32'd0);
        check("clearwins.block", 32'(block), 32'd0);
        clear = 1'b0;

        // Sub-loop idle bits do not mask cand; reset mid-suspect.
        inst_idle_sigs = 12'hF00; inst_block_sigs = 8'hFF;
        repeat (9) tick();
        check("subloop.count9", 32'(stall_count), 32'd9);
        reset = 1'b1;
        tick();
        check_all("midreset", 1'b0, 8'h00, 12'h000, 16'd0);
        reset = 1'b0;
        tick();
        check("postreset.count", 32'(stall_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
